// File: rtl/fpu_host_sequencer.sv
// fpu_host_sequencer: round-robin host running one 32-bit op on a byte-wide FPU port (req_*/rsp_* requester side, fpu_* bus side)
module fpu_host_sequencer #(
  parameter int NUM_REQ = 2,
  parameter int RD_LAT = 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [4*NUM_REQ-1:0]    req_op,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_result,
  output logic                    rsp_err,
  output logic [7:0]              fpu_data_out,
  input  logic [7:0]              fpu_data_in,
  output logic [3:0]              fpu_addr,
  output logic                    fpu_cs,
  output logic                    fpu_rd,
  output logic                    fpu_wr,
  output logic                    fpu_end_ack,
  input  logic                    fpu_cmd_end,
  input  logic                    fpu_busy
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, GRANT, WRITE, WAIT_END, READ, ACK, ABORT, RESP} state_t;
  state_t state, state_nx;
  logic [PW-1:0] ptr, owner, winner, j;
  logic [3:0] op, idx;
  logic [31:0] a, b, result;
  logic [63:0] ab;
  logic [1:0] lat;
  logic [TW-1:0] tcnt;
  logic rd_strobe, rd_sample;
  always_comb begin
    winner = ptr;
    j = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = PW'((32'(ptr) + 32'(k)) % NUM_REQ);
      if (req_valid[j]) winner = j;
    end
  end
  always_comb begin
    ab = {b, a};
    rd_strobe = state == READ && lat == 2'd0;
    rd_sample = state == READ && lat == 2'(RD_LAT);
    req_ready = (state == GRANT && |req_valid) ? NUM_REQ'(1) << winner : '0;
    rsp_valid = (state == RESP) ? NUM_REQ'(1) << owner : '0;
    fpu_wr = state == WRITE;
    fpu_rd = rd_strobe;
    fpu_cs = fpu_wr || fpu_rd;
    fpu_addr = fpu_wr ? idx : rd_strobe ? 4'd9 + idx : 4'd0;
    fpu_data_out = !fpu_wr ? 8'd0 : idx[3] ? {4'd0, op} : ab[{idx[2:0], 3'b000} +: 8];
    fpu_end_ack = (state == ACK && fpu_cmd_end) || state == ABORT;
    state_nx = (state == IDLE)     ? ((|req_valid && !fpu_busy) ? GRANT : IDLE) :
               (state == GRANT)    ? (|req_valid ? WRITE : IDLE) :
               (state == WRITE)    ? ((idx == 4'd8) ? WAIT_END : WRITE) :
               (state == WAIT_END) ? (fpu_cmd_end ? READ : (tcnt == TW'(TIMEOUT_CYC - 1)) ? ABORT : WAIT_END) :
               (state == READ)     ? ((rd_sample && idx == 4'd3) ? ACK : READ) :
               (state == ACK)      ? (fpu_cmd_end ? ACK : RESP) :
               (state == ABORT)    ? RESP : IDLE;
  end
  always_ff @(posedge clk) begin
    if (arst) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      op <= '0;
      a <= '0;
      b <= '0;
      result <= '0;
      idx <= '0;
      lat <= '0;
      tcnt <= '0;
      rsp_result <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == GRANT && |req_valid) begin
        owner <= winner;
        op <= req_op[4*32'(winner) +: 4];
        a <= req_a[32*32'(winner) +: 32];
        b <= req_b[32*32'(winner) +: 32];
        ptr <= (32'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
      end
      idx <= ((state == WRITE && idx != 4'd8) || rd_sample) ? idx + 4'd1 :
             (state == WRITE || state == READ) ? idx : 4'd0;
      lat <= (state == READ && !rd_sample) ? lat + 2'd1 : 2'd0;
      tcnt <= (state == WAIT_END) ? tcnt + 1'b1 : '0;
      if (rd_sample) result[{idx[1:0], 3'b000} +: 8] <= fpu_data_in;
      if (state_nx == RESP) begin
        rsp_result <= (state == ABORT) ? 32'd0 : result;
        rsp_err <= state == ABORT;
      end
    end
  end
endmodule

// File: tb/tb_fpu_host_sequencer.sv
// tb_fpu_host_sequencer: randomized self-checking bench with a byte-bus FPU model and a round-robin reference
module tb_fpu_host_sequencer;
  localparam int N = 2;
  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;
  logic [N-1:0] req_valid [2];
  logic [4*N-1:0] req_op [2];
  logic [32*N-1:0] req_a [2];
  logic [32*N-1:0] req_b [2];
  logic [N-1:0] req_ready [2];
  logic [N-1:0] rsp_valid [2];
  logic [31:0] rsp_result [2];
  logic rsp_err [2];
  logic [7:0] fpu_data_out [2];
  logic [7:0] fpu_data_in [2];
  logic [3:0] fpu_addr [2];
  logic fpu_cs [2];
  logic fpu_rd [2];
  logic fpu_wr [2];
  logic fpu_end_ack [2];
  logic fpu_cmd_end [2];
  logic fpu_busy [2];
  logic hang [2];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int ptr_m [2];
  logic [3:0] p_op [2][N];
  logic [31:0] p_a [2][N];
  logic [31:0] p_b [2][N];
  logic [31:0] last_res [2];
  int grant_cyc;
  int grant_log [$];
  logic [7:0] eb [9] = '{8'h00, 8'h00, 8'h80, 8'h3F, 8'h00, 8'h00, 8'h00, 8'h40, 8'h01};
  function automatic logic [31:0] fpu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 4'd1 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    return (a ^ {b[15:0], b[31:16]}) + {28'd0, op};
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  function automatic logic [52:0] outs(input int d);
    return {req_ready[d], rsp_valid[d], rsp_result[d], rsp_err[d], fpu_data_out[d],
            fpu_addr[d], fpu_cs[d], fpu_rd[d], fpu_wr[d], fpu_end_ack[d]};
  endfunction
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int L = (g == 0) ? 1 : 3;
    logic [7:0] regs [16];
    logic [7:0] pd [3];
    logic [2:0] pv;
    logic done;
    logic [3:0] wl_addr [256];
    logic [7:0] wl_data [256];
    int wl_cyc [256];
    int wn = 0;
    assign fpu_cmd_end[g] = done;
    assign fpu_data_in[g] = pv[L-1] ? pd[L-1] : 8'hEE;
    fpu_host_sequencer #(.NUM_REQ(N), .RD_LAT(L), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .arst(arst),
      .req_valid(req_valid[g]), .req_op(req_op[g]), .req_a(req_a[g]), .req_b(req_b[g]),
      .req_ready(req_ready[g]), .rsp_valid(rsp_valid[g]), .rsp_result(rsp_result[g]), .rsp_err(rsp_err[g]),
      .fpu_data_out(fpu_data_out[g]), .fpu_data_in(fpu_data_in[g]), .fpu_addr(fpu_addr[g]),
      .fpu_cs(fpu_cs[g]), .fpu_rd(fpu_rd[g]), .fpu_wr(fpu_wr[g]), .fpu_end_ack(fpu_end_ack[g]),
      .fpu_cmd_end(fpu_cmd_end[g]), .fpu_busy(fpu_busy[g])
    );
    always @(posedge clk) begin
      pv <= {pv[1:0], fpu_cs[g] & fpu_rd[g]};
      pd[0] <= regs[fpu_addr[g]];
      pd[1] <= pd[0];
      pd[2] <= pd[1];
      if (fpu_end_ack[g]) done <= 1'b0;
      if (fpu_cs[g] && fpu_wr[g]) begin
        regs[fpu_addr[g]] <= fpu_data_out[g];
        if (wn < 256) begin
          wl_addr[wn] <= fpu_addr[g];
          wl_data[wn] <= fpu_data_out[g];
          wl_cyc[wn] <= cyc;
        end
        wn <= wn + 1;
        if (fpu_addr[g] == 4'd8) begin
          {regs[12], regs[11], regs[10], regs[9]} <= fpu_fn(fpu_data_out[g][3:0],
            {regs[3], regs[2], regs[1], regs[0]}, {regs[7], regs[6], regs[5], regs[4]});
          done <= !hang[g];
        end
      end
      if (arst) begin
        pv <= '0;
        done <= 1'b0;
      end
    end
    always @(negedge clk)
      if (!arst) chk("bus_rules", {fpu_rd[g] && fpu_wr[g], fpu_cs[g] == (fpu_rd[g] || fpu_wr[g]),
                                   $onehot0(req_ready[g]), $onehot0(rsp_valid[g])}, 4'b0111);
  end
  task automatic new_req(input int d, input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    p_op[d][r] = op;
    p_a[d][r] = a;
    p_b[d][r] = b;
    req_op[d][4*r +: 4] = op;
    req_a[d][32*r +: 32] = a;
    req_b[d][32*r +: 32] = b;
    req_valid[d][r] = 1'b1;
  endtask
  task automatic run(input int d, input int total, input int issued_in, input bit abort);
    int issued, got, owner, drop, last_wr, first_ack, ack_n;
    logic [31:0] exp_r;
    issued = issued_in;
    got = 0;
    owner = 0;
    drop = -1;
    last_wr = 0;
    first_ack = 0;
    ack_n = 0;
    exp_r = '0;
    for (int t = 0; t < 3000 && got < total; t++) begin
      @(negedge clk);
      if (drop >= 0) begin
        if (issued < total) begin
          new_req(d, drop, 4'($urandom), $urandom, $urandom);
          issued++;
        end else req_valid[d][drop] = 1'b0;
        drop = -1;
      end
      if (fpu_wr[d]) last_wr = cyc;
      if (fpu_end_ack[d]) begin
        if (ack_n == 0) first_ack = cyc;
        ack_n++;
      end
      if (req_ready[d] != '0) begin
        int w;
        w = -1;
        for (int k = N - 1; k >= 0; k--) if (req_valid[d][(ptr_m[d] + k) % N]) w = (ptr_m[d] + k) % N;
        chk("grant", 64'(req_ready[d]), (w < 0) ? 64'd0 : 64'd1 << w);
        if (w < 0) w = 0;
        owner = w;
        ptr_m[d] = (w + 1) % N;
        grant_cyc = cyc;
        grant_log.push_back(w);
        drop = w;
        exp_r = abort ? 32'd0 : fpu_fn(p_op[d][w], p_a[d][w], p_b[d][w]);
        ack_n = 0;
      end
      if (rsp_valid[d] != '0) begin
        chk("rsp_owner", 64'(rsp_valid[d]), 64'd1 << owner);
        chk("rsp_result", 64'(rsp_result[d]), 64'(exp_r));
        chk("rsp_err", 64'(rsp_err[d]), 64'(abort));
        chk("end_ack_pulses", 64'(ack_n), 64'd1);
        if (abort) chk("timeout_len", 64'(first_ack - last_wr), 64'd17);
        last_res[d] = exp_r;
        got++;
      end
    end
    chk("rsp_count", 64'(got), 64'(total));
  endtask
  initial begin
    int c0, w0, dropf;
    bit seen;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = '0;
      req_op[d] = '0;
      req_a[d] = '0;
      req_b[d] = '0;
      fpu_busy[d] = 1'b0;
      hang[d] = 1'b0;
      ptr_m[d] = 0;
      last_res[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) chk("reset_outputs", 64'(outs(d)), 64'd0);
    arst = 1'b0;
    @(negedge clk);
    new_req(0, 0, 4'd1, 32'h3F800000, 32'h40000000);
    c0 = cyc;
    w0 = u[0].wn;
    run(0, 1, 1, 1'b0);
    chk("ready_latency", 64'(grant_cyc - c0), 64'd1);
    chk("wr_count", 64'(u[0].wn - w0), 64'd9);
    for (int k = 0; k < 9; k++) begin
      chk("wr_addr", 64'(u[0].wl_addr[w0 + k]), 64'(k));
      chk("wr_data", 64'(u[0].wl_data[w0 + k]), 64'(eb[k]));
      chk("wr_cycle", 64'(u[0].wl_cyc[w0 + k] - u[0].wl_cyc[w0]), 64'(k));
    end
    fpu_busy[0] = 1'b1;
    new_req(0, 1, 4'($urandom), $urandom, $urandom);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("busy_stall", 64'({req_ready[0], fpu_cs[0], fpu_rd[0], fpu_wr[0]}), 64'd0);
    end
    chk("rsp_hold", 64'(rsp_result[0]), 64'h40400000);
    fpu_busy[0] = 1'b0;
    c0 = cyc;
    run(0, 1, 1, 1'b0);
    chk("busy_release_latency", 64'(grant_cyc - c0), 64'd1);
    grant_log.delete();
    new_req(0, 0, 4'($urandom), $urandom, $urandom);
    new_req(0, 1, 4'($urandom), $urandom, $urandom);
    run(0, 3, 2, 1'b0);
    chk("rr_order", (grant_log.size() == 3) ? 64'(grant_log[0] * 100 + grant_log[1] * 10 + grant_log[2]) : 64'hFFFF, 64'd10);
    hang[0] = 1'b1;
    new_req(0, 0, 4'($urandom), $urandom, $urandom);
    run(0, 1, 1, 1'b1);
    hang[0] = 1'b0;
    new_req(0, 1, 4'($urandom), $urandom, $urandom);
    seen = 1'b0;
    dropf = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (dropf != 0) req_valid[0][1] = 1'b0;
      if (req_ready[0][1]) dropf = 1;
      if (fpu_wr[0] && fpu_addr[0] == 4'd5) seen = 1'b1;
    end
    chk("reached_byte5", 64'(seen), 64'd1);
    arst = 1'b1;
    @(negedge clk);
    chk("reset_midop_outputs", 64'(outs(0)), 64'd0);
    arst = 1'b0;
    req_valid[0] = '0;
    ptr_m[0] = 0;
    ptr_m[1] = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("quiet_after_reset", 64'({rsp_valid[0], fpu_cs[0], fpu_end_ack[0]}), 64'd0);
    end
    new_req(0, 1, 4'($urandom), $urandom, $urandom);
    run(0, 1, 1, 1'b0);
    new_req(1, 0, 4'($urandom), $urandom, $urandom);
    new_req(1, 1, 4'($urandom), $urandom, $urandom);
    run(1, 4, 2, 1'b0);
    new_req(0, 0, 4'($urandom), $urandom, $urandom);
    new_req(0, 1, 4'($urandom), $urandom, $urandom);
    run(0, 6, 2, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
